axi_rd_responder: RTL and testbench



---
 rtl/axi_rd_responder.sv | 116 +++++++++++
 tb/tb_axi_rd_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: one burst at a time, one beat per FETCH/WAIT/SEND pass.
// Optional AXI_RD_RESP_4KB_CHECK_EN turns INCR bursts crossing a 4KB page into SLVERR bursts.
module axi_rd_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [LEN_WIDTH-1:0]  s_arlen,
    input  logic [1:0]            s_arburst,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            m_rresp,
    output logic [ID_WIDTH-1:0]   m_rid,
    output logic                  m_rlast,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          burst;
        logic                err;
    } cmd_t;

    state_t                state, state_n;
    cmd_t                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  ar_hs;
    logic                  ar_err;

    assign ar_hs    = s_arvalid & s_arready;
    assign mem_en   = (state == FETCH) && !cmd.err;
    assign mem_addr = addr;

    // WRAP and the reserved encoding both have burst[1] set.
`ifdef AXI_RD_RESP_4KB_CHECK_EN
    logic [31:0] end_off;
    always_comb begin
        end_off = 32'(s_araddr[11:0]) + (32'(s_arlen) + 32'd1) * 32'(BYTES);
        ar_err  = s_arburst[1];
        if (s_arburst == 2'b01 && end_off > 32'd4096)
            ar_err = 1'b1;
    end
`else
    always_comb ar_err = s_arburst[1];
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ar_hs) state_n = FETCH;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = SEND;
            SEND:    if (m_rready) state_n = m_rlast ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            s_arready <= 1'b0;
            cmd       <= '0;
            addr      <= '0;
            beat_cnt  <= '0;
            m_rvalid  <= 1'b0;
            m_rdata   <= '0;
            m_rresp   <= 2'b00;
            m_rid     <= '0;
            m_rlast   <= 1'b0;
        end else begin
            state     <= state_n;
            // Registered so it stays low while reset is held and rises on the first IDLE cycle.
            s_arready <= (state_n == IDLE);
            case (state)
                IDLE: if (ar_hs) begin
                    cmd      <= '{id: s_arid, burst: s_arburst, err: ar_err};
                    addr     <= s_araddr & ALIGN_MASK;
                    beat_cnt <= s_arlen;
                end
                WAIT: begin
                    m_rdata  <= cmd.err ? '0 : mem_rdata;
                    m_rresp  <= cmd.err ? 2'b10 : 2'b00;
                    m_rid    <= cmd.id;
                    m_rlast  <= (beat_cnt == '0);
                    m_rvalid <= 1'b1;
                end
                SEND: if (m_rready) begin
                    m_rvalid <= 1'b0;
                    if (!m_rlast) begin
                        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        if (cmd.burst == 2'b01)
                            addr <= addr + ADDR_WIDTH'(BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder; memory model returns addr ^ KEY one cycle after mem_en.
// Covers AXI_RD_RESP_4KB_CHECK_EN both when defined and when not.
module tb_axi_rd_responder;

    localparam logic [31:0] KEY = 32'hC3C3_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic [3:0]  s_arid = '0;
    logic [7:0]  s_arlen = '0;
    logic [1:0]  s_arburst = '0;
    logic        m_rvalid;
    logic        m_rready = 1'b0;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [3:0]  m_rid;
    logic        m_rlast;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_log[$];

    always #5 clk = ~clk;

    axi_rd_responder dut (
        .clk(clk), .resetn(resetn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_addr ^ KEY;
            mem_log.push_back(mem_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                           input logic [3:0] id, output bit ok);
        s_araddr = a; s_arlen = len; s_arburst = b; s_arid = id;
        s_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_arready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        s_arvalid = 1'b0;
    endtask

    // Waits for a beat, captures it, and completes the handshake.
    task automatic get_beat(output logic [31:0] d, output logic [1:0] r, output logic [3:0] id,
                            output bit last, output int waits, output bit ok);
        ok = 1'b0; waits = 0; d = '0; r = '0; id = '0; last = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_rvalid) begin
                d = m_rdata; r = m_rresp; id = m_rid; last = m_rlast;
                ok = 1'b1;
                m_rready = 1'b1;
                step();
                break;
            end
            waits++;
            step();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(); step();
        checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", s_arready); end
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", m_rvalid); end
        checks++; if (m_rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b want 0", m_rlast); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", m_rdata); end
        checks++; if ({m_rresp, m_rid} !== 6'h0) begin errors++; $display("FAIL rst_resp_id got %h want 0", {m_rresp, m_rid}); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        resetn = 1'b1;
        step();
        checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL idle_arready got %b want 1", s_arready); end
    endtask

    task automatic test_incr();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        mem_log.delete();
        m_rready = 1'b1;
        send_ar(32'h100, 8'd3, 2'b01, 4'd5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL incr_ar got timeout want handshake"); end
        for (int b = 0; b < 4; b++) begin
            get_beat(d, r, id, last, w, ok);
            checks++; if (!ok) begin errors++; $display("FAIL incr_beat%0d got timeout want beat", b); end
            checks++; if (d !== ((32'h100 + 32'(4 * b)) ^ KEY)) begin errors++; $display("FAIL incr_data%0d got %h want %h", b, d, (32'h100 + 32'(4 * b)) ^ KEY); end
            checks++; if ({r, id} !== {2'b00, 4'd5}) begin errors++; $display("FAIL incr_resp_id%0d got %h want 05", b, {r, id}); end
            checks++; if (last !== (b == 3)) begin errors++; $display("FAIL incr_last%0d got %b want %b", b, last, b == 3); end
            checks++; if (w + 1 !== 3) begin errors++; $display("FAIL incr_latency%0d got %0d want 3", b, w + 1); end
        end
        checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL incr_mem_cnt got %0d want 4", mem_log.size()); end
        for (int b = 0; b < 4 && b < mem_log.size(); b++) begin
            checks++; if (mem_log[b] !== 32'h100 + 32'(4 * b)) begin errors++; $display("FAIL incr_mem_addr%0d got %h want %h", b, mem_log[b], 32'h100 + 32'(4 * b)); end
        end
    endtask

    task automatic test_fixed();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        mem_log.delete();
        send_ar(32'h20, 8'd2, 2'b00, 4'd3, ok);
        for (int b = 0; b < 3; b++) begin
            get_beat(d, r, id, last, w, ok);
            checks++; if (!ok || d !== (32'h20 ^ KEY)) begin errors++; $display("FAIL fixed_data%0d got %h want %h", b, d, 32'h20 ^ KEY); end
            checks++; if ({r, id, last} !== {2'b00, 4'd3, b == 2}) begin errors++; $display("FAIL fixed_fields%0d got %h want %h", b, {r, id, last}, {2'b00, 4'd3, b == 2}); end
        end
        checks++; if (mem_log.size() !== 3) begin errors++; $display("FAIL fixed_mem_cnt got %0d want 3", mem_log.size()); end
        foreach (mem_log[i]) begin
            checks++; if (mem_log[i] !== 32'h20) begin errors++; $display("FAIL fixed_mem_addr%0d got %h want 20", i, mem_log[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        mem_log.delete();
        send_ar(32'h80, 8'd1, 2'b10, 4'd6, ok);
        for (int b = 0; b < 2; b++) begin
            get_beat(d, r, id, last, w, ok);
            checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL wrap_data%0d got %h want 0", b, d); end
            checks++; if ({r, id, last} !== {2'b10, 4'd6, b == 1}) begin errors++; $display("FAIL wrap_fields%0d got %h want %h", b, {r, id, last}, {2'b10, 4'd6, b == 1}); end
        end
        checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL wrap_arready got %b want 1", s_arready); end
        send_ar(32'h90, 8'd0, 2'b11, 4'd2, ok);
        get_beat(d, r, id, last, w, ok);
        checks++; if ({d, r, id, last} !== {32'h0, 2'b10, 4'd2, 1'b1}) begin errors++; $display("FAIL rsvd_beat got %h want %h", {d, r, id, last}, {32'h0, 2'b10, 4'd2, 1'b1}); end
        checks++; if (mem_log.size() !== 0) begin errors++; $display("FAIL wrap_mem_en got %0d want 0", mem_log.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        mem_log.delete();
        m_rready = 1'b0;
        send_ar(32'h40, 8'd1, 2'b01, 4'd2, ok);
        for (int i = 0; i < 10 && !m_rvalid; i++) step();
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== (32'h40 ^ KEY)) begin errors++; $display("FAIL bp_first got v=%b d=%h want v=1 d=%h", m_rvalid, m_rdata, 32'h40 ^ KEY); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({m_rvalid, m_rdata, m_rlast} !== {1'b1, 32'h40 ^ KEY, 1'b0} || mem_log.size() !== 1) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h l=%b mem=%0d want v=1 d=%h l=0 mem=1", i, m_rvalid, m_rdata, m_rlast, mem_log.size(), 32'h40 ^ KEY);
            end
        end
        get_beat(d, r, id, last, w, ok);
        get_beat(d, r, id, last, w, ok);
        checks++; if (!ok || {d, last} !== {32'h44 ^ KEY, 1'b1}) begin errors++; $display("FAIL bp_beat2 got %h want %h", {d, last}, {32'h44 ^ KEY, 1'b1}); end
        checks++; if (mem_log.size() !== 2) begin errors++; $display("FAIL bp_mem_cnt got %0d want 2", mem_log.size()); end
    endtask

    task automatic test_unaligned();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        bit busy_ok;
        mem_log.delete();
        m_rready = 1'b0;
        send_ar(32'h103, 8'd0, 2'b01, 4'd7, ok);
        s_araddr = 32'h500; s_arvalid = 1'b1;
        busy_ok = 1'b1;
        for (int i = 0; i < 10 && !m_rvalid; i++) begin
            if (s_arready) busy_ok = 1'b0;
            step();
        end
        checks++; if (!busy_ok || s_arready !== 1'b0) begin errors++; $display("FAIL una_arready got %b want 0", s_arready); end
        s_arvalid = 1'b0;
        get_beat(d, r, id, last, w, ok);
        checks++; if (!ok || {d, r, id, last} !== {32'h100 ^ KEY, 2'b00, 4'd7, 1'b1}) begin errors++; $display("FAIL una_beat got %h want %h", {d, r, id, last}, {32'h100 ^ KEY, 2'b00, 4'd7, 1'b1}); end
        checks++; if (mem_log.size() !== 1 || mem_log[0] !== 32'h100) begin errors++; $display("FAIL una_mem_addr got n=%0d want one access at 100", mem_log.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        bit quiet;
        m_rready = 1'b1;
        send_ar(32'h200, 8'd7, 2'b01, 4'd9, ok);
        get_beat(d, r, id, last, w, ok);
        checks++; if (!ok || d !== (32'h200 ^ KEY)) begin errors++; $display("FAIL rmid_beat1 got %h want %h", d, 32'h200 ^ KEY); end
        m_rready = 1'b0;
        for (int i = 0; i < 10 && !m_rvalid; i++) step();
        #2 resetn = 1'b0;
        #1;
        checks++; if ({m_rvalid, m_rlast, s_arready, mem_en} !== 4'b0000 || m_rdata !== 32'h0) begin errors++; $display("FAIL rmid_clear got v=%b l=%b ar=%b en=%b d=%h want all 0", m_rvalid, m_rlast, s_arready, mem_en, m_rdata); end
        step(); step();
        resetn = 1'b1;
        m_rready = 1'b1;
        mem_log.delete();
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_rvalid || mem_en) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rmid_quiet got activity want none"); end
        checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL rmid_arready got %b want 1", s_arready); end
        send_ar(32'h300, 8'd1, 2'b01, 4'd1, ok);
        for (int b = 0; b < 2; b++) begin
            get_beat(d, r, id, last, w, ok);
            checks++; if (!ok || {d, r, id, last} !== {(32'h300 + 32'(4 * b)) ^ KEY, 2'b00, 4'd1, b == 1}) begin errors++; $display("FAIL rmid_next%0d got %h want %h", b, {d, r, id, last}, {(32'h300 + 32'(4 * b)) ^ KEY, 2'b00, 4'd1, b == 1}); end
        end
    endtask

    task automatic test_4kb();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; bit last, ok; int w;
        mem_log.delete();
        m_rready = 1'b1;
        send_ar(32'hFF8, 8'd3, 2'b01, 4'd4, ok);
        for (int b = 0; b < 4; b++) begin
            get_beat(d, r, id, last, w, ok);
`ifdef AXI_RD_RESP_4KB_CHECK_EN
            checks++; if (!ok || {d, r, id, last} !== {32'h0, 2'b10, 4'd4, b == 3}) begin errors++; $display("FAIL 4kb_err%0d got %h want %h", b, {d, r, id, last}, {32'h0, 2'b10, 4'd4, b == 3}); end
`else
            checks++; if (!ok || {d, r, id, last} !== {(32'hFF8 + 32'(4 * b)) ^ KEY, 2'b00, 4'd4, b == 3}) begin errors++; $display("FAIL 4kb_cross%0d got %h want %h", b, {d, r, id, last}, {(32'hFF8 + 32'(4 * b)) ^ KEY, 2'b00, 4'd4, b == 3}); end
`endif
        end
`ifdef AXI_RD_RESP_4KB_CHECK_EN
        checks++; if (mem_log.size() !== 0) begin errors++; $display("FAIL 4kb_mem_en got %0d want 0", mem_log.size()); end
`else
        checks++; if (mem_log.size() !== 4 || mem_log[2] !== 32'h1000) begin errors++; $display("FAIL 4kb_mem got n=%0d want 4 with 1000 third", mem_log.size()); end
        mem_log.delete();
        send_ar(32'hFFFF_FFFC, 8'd1, 2'b01, 4'd8, ok);
        get_beat(d, r, id, last, w, ok);
        get_beat(d, r, id, last, w, ok);
        checks++; if (!ok || {d, last} !== {32'h0 ^ KEY, 1'b1}) begin errors++; $display("FAIL addr_wrap_data got %h want %h", {d, last}, {KEY, 1'b1}); end
        checks++; if (mem_log.size() !== 2 || mem_log[1] !== 32'h0) begin errors++; $display("FAIL addr_wrap_mem got n=%0d want 2 ending at 0", mem_log.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_wrap();
        test_backpressure();
        test_unaligned();
        test_reset_mid();
        test_4kb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
